// File: rtl/cozy_bus_pkg.sv
// Shared constants and helpers for the cozy memory bus: master indices,
// data/byte-enable widths and the read-detect helper.
package cozy_bus_pkg;
  localparam int DATA_W     = 16;
  localparam int BE_W       = 2;
  localparam int MASTER_CPU = 0;
  localparam int MASTER_AUX = 1;

  function automatic logic bwe_is_read(input logic [BE_W-1:0] bwe);
    return bwe == '0;
  endfunction
endpackage

// File: rtl/cozy_arb_core.sv
// Two-requester owner-priority round-robin arbiter with a burst cap.
// Produces a one-hot combinational grant and tracks owner/burst count.
module cozy_arb_core
  import cozy_bus_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel;
  logic             gidx;

  always_comb begin
    gnt     = '0;
    sel     = owner_q;
    owner_d = owner_q;
    cnt_d   = '0;
    if (!reset) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          // Owner keeps the port until its burst budget is spent.
          sel = (cnt_q < CNT_MAX) ? owner_q : ~owner_q;
          gnt = sel ? 2'b10 : 2'b01;
        end
        default: gnt = 2'b00;
      endcase
    end
    gidx = gnt[MASTER_AUX];
    if (gnt != 2'b00) begin
      if (gidx == owner_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        owner_d = gidx;
        cnt_d   = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/cozy_mem_arbiter.sv
// Shares one synchronous cozy_memory port between the CPU and an auxiliary
// master; read data returns to the granted master one cycle after its grant.
module cozy_mem_arbiter
  import cozy_bus_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [BE_W-1:0]      m0_bwe,
  input  logic [DATA_W-1:0]    m0_din,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [DATA_W-1:0]    m0_dout,
  input  logic                 m1_req,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [BE_W-1:0]      m1_bwe,
  input  logic [DATA_W-1:0]    m1_din,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [DATA_W-1:0]    m1_dout,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [BE_W-1:0]      mem_bwe,
  output logic [DATA_W-1:0]    mem_din,
  input  logic [DATA_W-1:0]    mem_dout
);
  logic [1:0] gnt;
  logic       rpend_q, rpend_d;
  logic       rsel_q, rsel_d;

  cozy_arb_core #(.MAX_BURST(MAX_BURST)) u_core (
    .clk   (clk),
    .reset (reset),
    .req   ({m1_req, m0_req}),
    .gnt   (gnt)
  );

  assign m0_gnt = gnt[MASTER_CPU];
  assign m1_gnt = gnt[MASTER_AUX];

  // Idle bus drives zeros so a stray write can never reach the memory.
  always_comb begin
    mem_addr = '0;
    mem_bwe  = '0;
    mem_din  = '0;
    if (gnt[MASTER_CPU]) begin
      mem_addr = m0_addr;
      mem_bwe  = m0_bwe;
      mem_din  = m0_din;
    end else if (gnt[MASTER_AUX]) begin
      mem_addr = m1_addr;
      mem_bwe  = m1_bwe;
      mem_din  = m1_din;
    end
  end

  always_comb begin
    rpend_d = (gnt != 2'b00) && bwe_is_read(mem_bwe);
    rsel_d  = rpend_d ? gnt[MASTER_AUX] : rsel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpend_q <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      rpend_q <= rpend_d;
      rsel_q  <= rsel_d;
    end
  end

  assign m0_rvalid = rpend_q && (rsel_q == 1'(MASTER_CPU));
  assign m1_rvalid = rpend_q && (rsel_q == 1'(MASTER_AUX));
  assign m0_dout   = m0_rvalid ? mem_dout : '0;
  assign m1_dout   = m1_rvalid ? mem_dout : '0;
endmodule
